// File: rtl/lcd_1602a_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_1602a_sequencer_if
// Description : Host request handshake and nibble-driver bus for the 1602A
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_1602a_sequencer_if;
    logic       host_valid;
    logic       host_rs;
    logic [7:0] host_data;
    logic       host_ready;
    logic       drv_en;
    logic       drv_rs;
    logic [7:0] drv_data;
    logic       drv_rdy;
    logic       drv_count;

    // Environment side: host logic plus the nibble driver
    modport master (
        output host_valid, host_rs, host_data, drv_rdy, drv_count,
        input  host_ready, drv_en, drv_rs, drv_data
    );

    modport slave (
        input  host_valid, host_rs, host_data, drv_rdy, drv_count,
        output host_ready, drv_en, drv_rs, drv_data
    );
endinterface
`default_nettype wire

// File: rtl/lcd_1602a_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_1602a_sequencer
// Description : 1602A front-end: power-on init, host byte requests, delay
//               checkpoint flags and automatic DDRAM line wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_1602a_sequencer #(
    parameter int CLK_MHZ = 20,
    parameter int COLS    = 16,
    parameter int CNT_W   = 20
) (
    input  wire logic             clk,
    input  wire logic             rst,
    lcd_1602a_sequencer_if.slave  bus,
    output logic [6:0]            flags_out,
    output logic                  init_done,
    output logic                  busy,
    output logic [3:0]            cur_col,
    output logic                  cur_line
);

    localparam logic [2:0] c_st_pwr_wait   = 3'd0;
    localparam logic [2:0] c_st_init_issue = 3'd1;
    localparam logic [2:0] c_st_xfer       = 3'd2;
    localparam logic [2:0] c_st_post_wait  = 3'd3;
    localparam logic [2:0] c_st_idle       = 3'd4;
    localparam logic [2:0] c_st_wrap_issue = 3'd5;

    localparam int c_t6_raw = (40 * CLK_MHZ + 999) / 1000;
    localparam logic [CNT_W-1:0] c_t6 = CNT_W'((c_t6_raw < 1) ? 1 : c_t6_raw);
    localparam logic [CNT_W-1:0] c_t5 = CNT_W'((250 * CLK_MHZ + 999) / 1000);
    localparam logic [CNT_W-1:0] c_t4 = CNT_W'(42 * CLK_MHZ);
    localparam logic [CNT_W-1:0] c_t3 = CNT_W'(100 * CLK_MHZ);
    localparam logic [CNT_W-1:0] c_t2 = CNT_W'(1640 * CLK_MHZ);
    localparam logic [CNT_W-1:0] c_t1 = CNT_W'(4100 * CLK_MHZ);
    localparam logic [CNT_W-1:0] c_t0 = CNT_W'(15000 * CLK_MHZ);
    localparam logic [4:0]       c_cols = 5'(COLS);
    localparam logic [2:0]       c_last_idx = 3'd5;

    logic [2:0]       r_state, w_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [2:0]       r_sel, w_sel_nxt;
    logic             r_seen_low, w_seen_nxt;
    logic             r_wrap_pend, w_wrap_nxt;
    logic             r_init_done, w_init_nxt;
    logic             r_host_ready, r_busy;
    logic             r_drv_en, w_en_nxt;
    logic             r_drv_rs, w_rs_nxt;
    logic [7:0]       r_drv_data, w_data_nxt;
    logic [3:0]       r_col, w_col_nxt;
    logic             r_line, w_line_nxt;
    logic [4:0]       w_col_inc;
    logic [7:0]       w_flags_ext;
    logic             w_enter_wait;

    // Init ROM: byte and the flag index that ends its post-delay
    function automatic logic [7:0] rom_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_byte = 8'h33;
            3'd1:    rom_byte = 8'h32;
            3'd2:    rom_byte = 8'h28;
            3'd3:    rom_byte = 8'h0C;
            3'd4:    rom_byte = 8'h06;
            default: rom_byte = 8'h01;
        endcase
    endfunction

    function automatic logic [2:0] rom_sel(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_sel = 3'd1;
            3'd1:    rom_sel = 3'd3;
            3'd2:    rom_sel = 3'd4;
            3'd3:    rom_sel = 3'd4;
            3'd4:    rom_sel = 3'd4;
            default: rom_sel = 3'd2;
        endcase
    endfunction

    assign flags_out = {r_cnt >= c_t6, r_cnt >= c_t5, r_cnt >= c_t4, r_cnt >= c_t3,
                        r_cnt >= c_t2, r_cnt >= c_t1, r_cnt >= c_t0};
    assign w_flags_ext  = {1'b0, flags_out};
    assign w_col_inc    = {1'b0, r_col} + 5'd1;
    assign w_enter_wait = (w_nxt == c_st_post_wait) && (r_state != c_st_post_wait);

    always_comb begin
        w_nxt      = r_state;
        w_idx_nxt  = r_idx;
        w_sel_nxt  = r_sel;
        w_seen_nxt = 1'b0;
        w_wrap_nxt = r_wrap_pend;
        w_init_nxt = r_init_done;
        w_en_nxt   = r_drv_en;
        w_rs_nxt   = r_drv_rs;
        w_data_nxt = r_drv_data;
        w_col_nxt  = r_col;
        w_line_nxt = r_line;
        case (r_state)
            c_st_pwr_wait: begin
                if (flags_out[0]) begin
                    w_nxt      = c_st_init_issue;
                    w_idx_nxt  = 3'd0;
                    w_en_nxt   = 1'b1;
                    w_rs_nxt   = 1'b0;
                    w_data_nxt = rom_byte(3'd0);
                    w_sel_nxt  = rom_sel(3'd0);
                end
            end
            c_st_init_issue, c_st_wrap_issue: begin
                w_nxt      = c_st_xfer;
                w_seen_nxt = ~bus.drv_rdy;
            end
            c_st_xfer: begin
                // Completion is a low-then-high on drv_rdy while drv_en is held
                w_seen_nxt = r_seen_low | ~bus.drv_rdy;
                if (r_seen_low && bus.drv_rdy) begin
                    w_nxt      = c_st_post_wait;
                    w_en_nxt   = 1'b0;
                    w_seen_nxt = 1'b0;
                end
            end
            c_st_post_wait: begin
                if (w_flags_ext[r_sel]) begin
                    if (!r_init_done) begin
                        if (r_idx == c_last_idx) begin
                            w_init_nxt = 1'b1;
                            w_nxt      = c_st_idle;
                        end else begin
                            w_idx_nxt  = r_idx + 3'd1;
                            w_nxt      = c_st_init_issue;
                            w_en_nxt   = 1'b1;
                            w_rs_nxt   = 1'b0;
                            w_data_nxt = rom_byte(r_idx + 3'd1);
                            w_sel_nxt  = rom_sel(r_idx + 3'd1);
                        end
                    end else if (r_wrap_pend) begin
                        w_nxt      = c_st_wrap_issue;
                        w_wrap_nxt = 1'b0;
                        w_en_nxt   = 1'b1;
                        w_rs_nxt   = 1'b0;
                        w_data_nxt = r_line ? 8'hC0 : 8'h80;
                        w_sel_nxt  = 3'd4;
                    end else begin
                        w_nxt = c_st_idle;
                    end
                end
            end
            c_st_idle: begin
                if (bus.host_valid && r_host_ready) begin
                    w_nxt      = c_st_xfer;
                    w_en_nxt   = 1'b1;
                    w_rs_nxt   = bus.host_rs;
                    w_data_nxt = bus.host_data;
                    w_sel_nxt  = 3'd4;
                    if (bus.host_rs) begin
                        if (w_col_inc == c_cols) begin
                            w_col_nxt  = 4'd0;
                            w_line_nxt = ~r_line;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_col_nxt = w_col_inc[3:0];
                        end
                    end else if ((bus.host_data == 8'h01) || (bus.host_data == 8'h02) ||
                                 (bus.host_data == 8'h03)) begin
                        w_col_nxt  = 4'd0;
                        w_line_nxt = 1'b0;
                        w_sel_nxt  = 3'd2;
                    end else if (bus.host_data[7]) begin
                        w_col_nxt  = bus.host_data[3:0];
                        w_line_nxt = bus.host_data[6];
                    end
                end
            end
            default: w_nxt = c_st_pwr_wait;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_st_pwr_wait;
            r_idx        <= 3'd0;
            r_sel        <= 3'd0;
            r_seen_low   <= 1'b0;
            r_wrap_pend  <= 1'b0;
            r_init_done  <= 1'b0;
            r_host_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_drv_en     <= 1'b0;
            r_drv_rs     <= 1'b0;
            r_drv_data   <= 8'd0;
            r_col        <= 4'd0;
            r_line       <= 1'b0;
        end else begin
            r_state      <= w_nxt;
            r_idx        <= w_idx_nxt;
            r_sel        <= w_sel_nxt;
            r_seen_low   <= w_seen_nxt;
            r_wrap_pend  <= w_wrap_nxt;
            r_init_done  <= w_init_nxt;
            r_host_ready <= (w_nxt == c_st_idle) && w_init_nxt;
            r_busy       <= (w_nxt != c_st_idle);
            r_drv_en     <= w_en_nxt;
            r_drv_rs     <= w_rs_nxt;
            r_drv_data   <= w_data_nxt;
            r_col        <= w_col_nxt;
            r_line       <= w_line_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (bus.drv_count || w_enter_wait) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.host_ready = r_host_ready;
    assign bus.drv_en     = r_drv_en;
    assign bus.drv_rs     = r_drv_rs;
    assign bus.drv_data   = r_drv_data;
    assign init_done      = r_init_done;
    assign busy           = r_busy;
    assign cur_col        = r_col;
    assign cur_line       = r_line;

endmodule
`default_nettype wire

// File: tb/tb_lcd_1602a_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_1602a_sequencer
// Description : Directed bench for lcd_1602a_sequencer at CLK_MHZ=1
//               (T4=42, T3=100, T2=1640, T1=4100, T0=15000 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_1602a_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] flags_out;
    logic       init_done;
    logic       busy;
    logic [3:0] cur_col;
    logic       cur_line;
    int         vectors     = 0;
    int         miscompares = 0;

    lcd_1602a_sequencer_if bus ();

    lcd_1602a_sequencer #(
        .CLK_MHZ (1),
        .COLS    (16),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .flags_out (flags_out),
        .init_done (init_done),
        .busy      (busy),
        .cur_col   (cur_col),
        .cur_line  (cur_line)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input int max, output int n);
        n = 0;
        while (bus.drv_en !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        if (bus.drv_en !== 1'b1) n = -1;
    endtask

    task automatic wait_ready(input int max, output int n);
        n = 0;
        while (bus.host_ready !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        if (bus.host_ready !== 1'b1) n = -1;
    endtask

    // Driver model: drv_rdy pulses low one cycle after drv_en rises
    task automatic finish_xfer;
        tick();
        bus.drv_rdy = 1'b0;
        tick();
        bus.drv_rdy = 1'b1;
        tick();
    endtask

    task automatic host_send(input logic rs, input logic [7:0] data);
        bus.host_valid = 1'b1;
        bus.host_rs    = rs;
        bus.host_data  = data;
        tick();
        bus.host_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst            = 1'b0;
        bus.host_valid = 1'b0;
        bus.host_rs    = 1'b0;
        bus.host_data  = 8'd0;
        bus.drv_rdy    = 1'b1;
        bus.drv_count  = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({bus.host_ready, bus.drv_en, bus.drv_rs, bus.drv_data, init_done, busy,
             cur_col, cur_line} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {bus.host_ready, bus.drv_en, bus.drv_rs, bus.drv_data, init_done, busy,
                      cur_col, cur_line});
        end
        vectors++;
        if (flags_out !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 0000000", flags_out);
        end
    endtask

    task automatic test_init;
        logic [7:0] init_bytes [6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};
        int         init_gaps  [5] = '{4101, 101, 43, 43, 43};
        int         n;
        rst = 1'b1;
        wait_en(20000, n);
        vectors++;
        if (n !== 15001) begin
            miscompares++;
            $display("FAIL first_en_latency: got %0d expected 15001", n);
        end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                wait_en(5000, n);
                vectors++;
                if (n !== init_gaps[i-1]) begin
                    miscompares++;
                    $display("FAIL init_gap_%0d: got %0d expected %0d", i, n, init_gaps[i-1]);
                end
            end
            vectors++;
            if ({bus.drv_rs, bus.drv_data} !== {1'b0, init_bytes[i]}) begin
                miscompares++;
                $display("FAIL init_byte_%0d: got %h expected %h", i,
                         {bus.drv_rs, bus.drv_data}, {1'b0, init_bytes[i]});
            end
            finish_xfer();
            vectors++;
            if (bus.drv_en !== 1'b0) begin
                miscompares++;
                $display("FAIL init_en_drop_%0d: got %b expected 0", i, bus.drv_en);
            end
        end
        n = 0;
        while (init_done !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 1641) begin
            miscompares++;
            $display("FAIL init_done_latency: got %0d expected 1641", n);
        end
        vectors++;
        if ({bus.host_ready, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL init_idle_status: got ready,busy=%b expected 10",
                     {bus.host_ready, busy});
        end
    endtask

    task automatic test_char;
        int n;
        wait_ready(10, n);
        host_send(1'b1, 8'h41);
        vectors++;
        if ({bus.drv_en, bus.drv_rs, bus.drv_data} !== 10'h341) begin
            miscompares++;
            $display("FAIL char_launch: got %h expected 341", {bus.drv_en, bus.drv_rs, bus.drv_data});
        end
        vectors++;
        if ({cur_line, cur_col, bus.host_ready, busy} !== 7'b0_0001_01) begin
            miscompares++;
            $display("FAIL char_status: got %b expected 0000101",
                     {cur_line, cur_col, bus.host_ready, busy});
        end
        finish_xfer();
        wait_ready(200, n);
        vectors++;
        if (n !== 43) begin
            miscompares++;
            $display("FAIL char_post_delay: got %0d expected 43", n);
        end
    endtask

    task automatic test_clear;
        int n;
        for (int k = 0; k < 6; k++) begin
            wait_ready(200, n);
            host_send(1'b1, 8'(8'h42 + k));
            finish_xfer();
        end
        vectors++;
        if (cur_col !== 4'd7) begin
            miscompares++;
            $display("FAIL midline_col: got %0d expected 7", cur_col);
        end
        wait_ready(200, n);
        host_send(1'b0, 8'h01);
        vectors++;
        if ({cur_line, cur_col, bus.drv_rs, bus.drv_data} !== 14'h0001) begin
            miscompares++;
            $display("FAIL clear_cursor: got %h expected 0001",
                     {cur_line, cur_col, bus.drv_rs, bus.drv_data});
        end
        finish_xfer();
        wait_ready(3000, n);
        vectors++;
        if (n !== 1641) begin
            miscompares++;
            $display("FAIL clear_post_delay: got %0d expected 1641", n);
        end
    endtask

    task automatic test_wrap;
        int         n;
        logic       exp_line;
        logic [7:0] exp_cmd;
        for (int pass = 0; pass < 2; pass++) begin
            exp_line = (pass == 0);
            exp_cmd  = (pass == 0) ? 8'hC0 : 8'h80;
            for (int k = 0; k < 16; k++) begin
                wait_ready(200, n);
                host_send(1'b1, 8'(8'h61 + k));
                if (k == 15) begin
                    vectors++;
                    if ({cur_line, cur_col} !== {exp_line, 4'd0}) begin
                        miscompares++;
                        $display("FAIL wrap%0d_cursor: got %b expected %b", pass,
                                 {cur_line, cur_col}, {exp_line, 4'd0});
                    end
                end
                finish_xfer();
            end
            wait_en(200, n);
            vectors++;
            if (n !== 43) begin
                miscompares++;
                $display("FAIL wrap%0d_latency: got %0d expected 43", pass, n);
            end
            vectors++;
            if ({bus.host_ready, bus.drv_rs, bus.drv_data} !== {2'b00, exp_cmd}) begin
                miscompares++;
                $display("FAIL wrap%0d_cmd: got %h expected %h", pass,
                         {bus.host_ready, bus.drv_rs, bus.drv_data}, {2'b00, exp_cmd});
            end
            finish_xfer();
            wait_ready(200, n);
            vectors++;
            if (n !== 43) begin
                miscompares++;
                $display("FAIL wrap%0d_ready: got %0d expected 43", pass, n);
            end
        end
    endtask

    task automatic test_setpos;
        int n;
        wait_ready(200, n);
        host_send(1'b0, 8'hC5);
        vectors++;
        if ({cur_line, cur_col} !== 5'b1_0101) begin
            miscompares++;
            $display("FAIL setpos_cursor: got %b expected 10101", {cur_line, cur_col});
        end
        finish_xfer();
        wait_ready(200, n);
        vectors++;
        if (n !== 43) begin
            miscompares++;
            $display("FAIL setpos_no_wrap: got %0d expected 43", n);
        end
        for (int k = 0; k < 11; k++) begin
            wait_ready(200, n);
            host_send(1'b1, 8'(8'h30 + k));
            finish_xfer();
        end
        vectors++;
        if ({cur_line, cur_col} !== 5'b0_0000) begin
            miscompares++;
            $display("FAIL setpos_wrap_cursor: got %b expected 00000", {cur_line, cur_col});
        end
        wait_en(200, n);
        vectors++;
        if ({bus.drv_rs, bus.drv_data} !== 9'h080 || n !== 43) begin
            miscompares++;
            $display("FAIL setpos_wrap_cmd: got %h after %0d expected 080 after 43",
                     {bus.drv_rs, bus.drv_data}, n);
        end
        finish_xfer();
        wait_ready(200, n);
    endtask

    task automatic test_reset_mid_xfer;
        int n;
        wait_ready(200, n);
        host_send(1'b1, 8'h5A);
        tick();
        bus.drv_rdy = 1'b0;
        vectors++;
        if (bus.drv_en !== 1'b1) begin
            miscompares++;
            $display("FAIL midxfer_en: got %b expected 1", bus.drv_en);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({bus.drv_en, busy, init_done, bus.host_ready, cur_line, cur_col} !== 9'd0) begin
            miscompares++;
            $display("FAIL midxfer_reset: got %b expected 000000000",
                     {bus.drv_en, busy, init_done, bus.host_ready, cur_line, cur_col});
        end
        bus.drv_rdy = 1'b1;
        rst         = 1'b1;
        wait_en(20000, n);
        vectors++;
        if (n !== 15001 || {bus.drv_rs, bus.drv_data} !== 9'h033) begin
            miscompares++;
            $display("FAIL restart_init: got %h after %0d expected 033 after 15001",
                     {bus.drv_rs, bus.drv_data}, n);
        end
        finish_xfer();
        repeat (200) tick();
        vectors++;
        if (flags_out !== 7'b1111000) begin
            miscompares++;
            $display("FAIL flags_at_200: got %b expected 1111000", flags_out);
        end
        bus.drv_count = 1'b1;
        tick();
        bus.drv_count = 1'b0;
        vectors++;
        if (flags_out !== 7'd0) begin
            miscompares++;
            $display("FAIL drv_count_clear: got %b expected 0000000", flags_out);
        end
        wait_en(5000, n);
        vectors++;
        if (n !== 4101 || {bus.drv_rs, bus.drv_data} !== 9'h032) begin
            miscompares++;
            $display("FAIL restart_second_byte: got %h after %0d expected 032 after 4101",
                     {bus.drv_rs, bus.drv_data}, n);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_char();
        test_clear();
        test_wrap();
        test_setpos();
        test_reset_mid_xfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
